// File: rtl/net_arq_sender.sv
// net_arq_sender: multi-lane stop-and-wait ARQ serial transmitter.
//
// One payload word per packet is framed across LANES serial lines in
// lockstep, one bit per bit_tick, MSB first:
//   start(1) | seq_num | lane payload | even parity(seq+payload) | stop(0)
// After the stop bit the sender waits for an ACK carrying the current
// sequence number. If none arrives within TIMEOUT_TICKS ticks, the frame is
// retransmitted, up to MAX_RETRIES times, and then send_fail is pulsed.
//
// Ports:
//   clk, rst_l        clock, synchronous active-low reset
//   bit_tick          one-clk strobe per serial bit period
//   data_valid/ready  payload handshake (ready only in IDLE)
//   data_in           LANES x PAYLOAD_BITS payload, lane k at k*PAYLOAD_BITS
//   ack_received      one-clk ACK pulse, ack_seqNum = its sequence number
//   serial_out        registered serial lines, idle low
//   seq_num           sequence number of the current/next packet
//   retry_cnt         retransmissions of the current packet
//   send_done         one-clk pulse: packet ACKed
//   send_fail         one-clk pulse: retries exhausted

// Per-lane frame builder: selects frame bit idx (0 = start bit).
module net_arq_lane #(
  parameter int PAYLOAD_BITS = 8,
  parameter int SEQ_BITS     = 1,
  parameter int IDX_W        = 4
) (
  input  logic [SEQ_BITS-1:0]     seq,
  input  logic [PAYLOAD_BITS-1:0] payload,
  input  logic [IDX_W-1:0]        idx,
  output logic                    line_bit
);
  localparam int F = SEQ_BITS + PAYLOAD_BITS + 3;

  logic [F-1:0] frame, frame_sh;

  always_comb begin
    frame    = {1'b1, seq, payload, ^{seq, payload}, 1'b0};
    // shift keeps the index arithmetic width-clean; bit F-1 is the current bit
    frame_sh = frame << idx;
    line_bit = frame_sh[F-1];
  end
endmodule

module net_arq_sender #(
  parameter int LANES         = 5,
  parameter int PAYLOAD_BITS  = 8,
  parameter int SEQ_BITS      = 1,
  parameter int TIMEOUT_TICKS = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic                             bit_tick,
  input  logic                             data_valid,
  input  logic [LANES*PAYLOAD_BITS-1:0]    data_in,
  output logic                             data_ready,
  input  logic                             ack_received,
  input  logic [SEQ_BITS-1:0]              ack_seqNum,
  output logic [LANES-1:0]                 serial_out,
  output logic [SEQ_BITS-1:0]              seq_num,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic                             send_done,
  output logic                             send_fail
);
  localparam int F  = SEQ_BITS + PAYLOAD_BITS + 3;
  localparam int CW = $clog2(F + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t                             state, state_nx;
  logic [LANES-1:0][PAYLOAD_BITS-1:0] payload;
  logic [CW-1:0]                      bit_cnt;   // frame bits already driven
  logic [TW-1:0]                      timer;
  logic [LANES-1:0]                   lane_bit;
  logic accept, frame_end, ack_ok, time_up, can_retry;

  assign data_ready = (state == IDLE);
  assign accept     = data_valid && data_ready;
  // tick after the stop bit: lines drop and the ACK wait begins
  assign frame_end  = (state == SEND) && bit_tick && (bit_cnt == CW'(F));
  assign ack_ok     = (state == WAIT_ACK) && ack_received && (ack_seqNum == seq_num);
  // a matching ACK in the same cycle wins over the timeout
  assign time_up    = (state == WAIT_ACK) && bit_tick && !ack_ok &&
                      (timer == TW'(TIMEOUT_TICKS - 1));
  assign can_retry  = retry_cnt < RW'(MAX_RETRIES);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    net_arq_lane #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .SEQ_BITS    (SEQ_BITS),
      .IDX_W       (CW)
    ) u_lane (
      .seq     (seq_num),
      .payload (payload[k]),
      .idx     (bit_cnt),
      .line_bit(lane_bit[k])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = SEND;
      SEND:     if (frame_end) state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_ok)       state_nx = IDLE;
        else if (time_up) state_nx = can_retry ? SEND : IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      payload    <= '0;
      bit_cnt    <= '0;
      timer      <= '0;
      serial_out <= '0;
      seq_num    <= '0;
      retry_cnt  <= '0;
      send_done  <= 1'b0;
      send_fail  <= 1'b0;
    end else begin
      send_done <= ack_ok;
      send_fail <= time_up && !can_retry;

      if (accept) begin
        payload   <= data_in;
        retry_cnt <= '0;
        bit_cnt   <= '0;
      end

      if (state == SEND && bit_tick) begin
        if (frame_end) begin
          serial_out <= '0;
          timer      <= '0;
        end else begin
          serial_out <= lane_bit;
          bit_cnt    <= bit_cnt + 1'b1;
        end
      end

      if (state == WAIT_ACK && bit_tick) timer <= timer + 1'b1;

      if (ack_ok) seq_num <= seq_num + 1'b1;

      // retransmit the latched frame unchanged
      if (time_up && can_retry) begin
        retry_cnt <= retry_cnt + 1'b1;
        bit_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_net_arq_sender.sv
// Bench for net_arq_sender: queue-based behavioural model checked every cycle
// on a default-parameter instance, plus directed literal checks on both a
// default instance and a SEQ_BITS=2 / 2-lane instance.
module tb_net_arq_sender;
  localparam int LN = 5, PB = 8, SB = 1, TO = 64, MR = 3;
  localparam int F  = SB + PB + 3;
  localparam int B_LN = 2, B_SB = 2, B_TO = 8, B_MR = 1;
  localparam int B_F = B_SB + PB + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l, bit_tick;

  logic            a_valid, a_ready, a_ack, a_done, a_fail;
  logic [LN*PB-1:0] a_data;
  logic [SB-1:0]   a_ack_seq, a_seq;
  logic [LN-1:0]   a_serial;
  logic [1:0]      a_retry;

  logic            b_valid, b_ready, b_ack, b_done, b_fail;
  logic [B_LN*PB-1:0] b_data;
  logic [B_SB-1:0] b_ack_seq, b_seq;
  logic [B_LN-1:0] b_serial;
  logic [0:0]      b_retry;

  int checks = 0, failures = 0;
  int tick_period = 4, tcnt = 0;
  int a_fail_seen = 0;

  net_arq_sender #(.LANES(LN), .PAYLOAD_BITS(PB), .SEQ_BITS(SB),
                   .TIMEOUT_TICKS(TO), .MAX_RETRIES(MR)) u_a (
    .clk(clk), .rst_l(rst_l), .bit_tick(bit_tick),
    .data_valid(a_valid), .data_in(a_data), .data_ready(a_ready),
    .ack_received(a_ack), .ack_seqNum(a_ack_seq),
    .serial_out(a_serial), .seq_num(a_seq), .retry_cnt(a_retry),
    .send_done(a_done), .send_fail(a_fail));

  net_arq_sender #(.LANES(B_LN), .PAYLOAD_BITS(PB), .SEQ_BITS(B_SB),
                   .TIMEOUT_TICKS(B_TO), .MAX_RETRIES(B_MR)) u_b (
    .clk(clk), .rst_l(rst_l), .bit_tick(bit_tick),
    .data_valid(b_valid), .data_in(b_data), .data_ready(b_ready),
    .ack_received(b_ack), .ack_seqNum(b_ack_seq),
    .serial_out(b_serial), .seq_num(b_seq), .retry_cnt(b_retry),
    .send_done(b_done), .send_fail(b_fail));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (default instance) ----------------
  // A packet becomes a queue of per-tick line words (F frame words plus a
  // trailing all-low word); popping the last word starts the ACK wait.
  logic [LN-1:0]    m_q[$];
  bit               m_idle = 1'b1, m_done = 1'b0, m_fail = 1'b0;
  int               m_wait = 0, m_retry = 0;
  logic [LN*PB-1:0] m_pay = '0;
  logic [SB-1:0]    m_seq = '0;
  logic [LN-1:0]    m_line = '0;

  task automatic model_load();
    logic [F-1:0]  frm [LN];
    logic [PB-1:0] pl;
    logic [LN-1:0] w;
    int            ones;
    for (int k = 0; k < LN; k++) begin
      pl = m_pay[k*PB +: PB];
      ones = $countones({m_seq, pl});
      frm[k] = {1'b1, m_seq, pl, (ones % 2) == 1, 1'b0};
    end
    for (int b = F - 1; b >= 0; b--) begin
      w = '0;
      for (int k = 0; k < LN; k++) w[k] = frm[k][b];
      m_q.push_back(w);
    end
    m_q.push_back('0);
  endtask

  task automatic model_step();
    if (!rst_l) begin
      m_q.delete(); m_idle = 1'b1; m_wait = 0; m_pay = '0; m_seq = '0;
      m_retry = 0; m_done = 1'b0; m_fail = 1'b0; m_line = '0;
      return;
    end
    m_done = 1'b0; m_fail = 1'b0;
    if (m_idle) begin
      if (a_valid) begin
        m_pay = a_data; m_retry = 0; m_idle = 1'b0; model_load();
      end
    end else if (m_q.size() > 0) begin
      if (bit_tick) begin m_line = m_q.pop_front(); m_wait = 0; end
    end else begin
      if (a_ack && a_ack_seq == m_seq) begin
        m_seq = m_seq + 1'b1; m_done = 1'b1; m_idle = 1'b1;
      end else if (bit_tick) begin
        m_wait++;
        if (m_wait == TO) begin
          if (m_retry < MR) begin m_retry++; model_load(); end
          else begin m_fail = 1'b1; m_idle = 1'b1; end
        end
      end
    end
  endtask

  // inputs change at negedge+1, so at negedge they are the values the DUT
  // sampled on the preceding posedge
  initial forever begin
    @(negedge clk);
    model_step();
    chk("model_serial_out", a_serial, m_line);
    chk("model_data_ready", a_ready, m_idle);
    chk("model_seq_num", a_seq, m_seq);
    chk("model_retry_cnt", a_retry, m_retry);
    chk("model_send_done", a_done, m_done);
    chk("model_send_fail", a_fail, m_fail);
    if (a_fail === 1'b1) a_fail_seen++;
  end

  initial begin
    bit_tick = 1'b0;
    forever begin
      @(negedge clk); #1;
      tcnt++;
      bit_tick = (tcnt % tick_period) == 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Records one frame (first tick with lane0 high = start bit), MSB first.
  logic [15:0] cap [LN];
  task automatic capture(input bit use_b, input int nbits);
    int n = 0, budget = 2000;
    logic [LN-1:0] ln;
    for (int k = 0; k < LN; k++) cap[k] = '0;
    while (n < nbits && budget > 0) begin
      @(negedge clk); budget--;
      ln = use_b ? {3'b000, b_serial} : a_serial;
      if (bit_tick && (n > 0 || ln[0])) begin
        for (int k = 0; k < LN; k++) cap[k] = {cap[k][14:0], ln[k]};
        n++;
      end
    end
    if (n < nbits) begin
      checks++; failures++;
      $display("FAIL capture_timeout bits=%0d required=%0d", n, nbits);
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [15:0] bdat [4];

  initial begin
    rst_l = 1'b0; a_valid = 0; a_data = '0; a_ack = 0; a_ack_seq = '0;
    b_valid = 0; b_data = '0; b_ack = 0; b_ack_seq = '0;
    bdat[0] = 16'h0000; bdat[1] = 16'h0001; bdat[2] = 16'h0000; bdat[3] = 16'hFFFF;
    step(3);
    chk("rst_serial", a_serial, 0);
    chk("rst_seq", a_seq, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_retry", a_retry, 0);
    chk("rst_done", a_done, 0);
    chk("rst_fail", a_fail, 0);
    chk("rst_b_serial", b_serial, 0);
    rst_l = 1'b1;
    step(2);

    // basic frame, tick every 4 clocks
    a_data = 40'h00_0000_00A5; a_valid = 1; step(1);
    a_valid = 0; a_data = '1;   // must be ignored
    capture(0, F);
    chk("t1_lane0", cap[0], 16'hA94);
    for (int k = 1; k < LN; k++) chk($sformatf("t1_lane%0d", k), cap[k], 16'h800);
    step(9);
    a_ack = 1; a_ack_seq = 0; step(1); a_ack = 0;
    chk("t1_done", a_done, 1);
    chk("t1_seq", a_seq, 1);
    chk("t1_ready", a_ready, 1);

    // reset during payload bit 5
    tick_period = 1; step(1);
    a_data = '1; a_valid = 1; step(1); a_valid = 0;
    step(6);
    chk("t6_pre_reset_lines", a_serial, 5'h1F);
    rst_l = 0; step(1);
    chk("t6_serial", a_serial, 0);
    chk("t6_seq", a_seq, 0);
    chk("t6_ready", a_ready, 1);
    rst_l = 1; step(1);

    // no ACK: 4 transmissions then send_fail
    a_data = 40'h00_0000_003C; a_valid = 1; step(1); a_valid = 0;
    for (int r = 0; r < 4; r++) begin
      capture(0, F);
      chk($sformatf("t2_lane0_tx%0d", r), cap[0], 16'h8F0);
      chk($sformatf("t2_lane1_tx%0d", r), cap[1], 16'h800);
      chk($sformatf("t2_retry_tx%0d", r), a_retry, r);
    end
    begin
      int w = 0;
      while (a_fail !== 1'b1 && w < 200) begin step(1); w++; end
    end
    chk("t2_fail_pulse", a_fail, 1);
    chk("t2_retry_final", a_retry, 3);
    chk("t2_seq", a_seq, 0);
    chk("t2_ready", a_ready, 1);
    step(1);
    chk("t2_fail_one_clk", a_fail, 0);
    chk("t2_fail_count", a_fail_seen, 1);

    // mismatched ACK ignored
    a_data = 40'h00_0000_0001; a_valid = 1; step(1); a_valid = 0;
    chk("t3_retry_clr", a_retry, 0);
    capture(0, F);
    chk("t3_lane0", cap[0], 16'h806);
    step(5);
    a_ack = 1; a_ack_seq = 1; step(1); a_ack = 0;
    chk("t3_no_done", a_done, 0);
    chk("t3_seq_hold", a_seq, 0);
    capture(0, F);
    chk("t3_lane0_retx", cap[0], 16'h806);
    chk("t3_retry", a_retry, 1);
    step(5);
    a_ack = 1; a_ack_seq = 0; step(1); a_ack = 0;
    chk("t3_done", a_done, 1);
    chk("t3_seq", a_seq, 1);

    // matching ACK on the timeout tick (tick every clock)
    a_data = 40'h00_0000_0055; a_valid = 1; step(1); a_valid = 0;
    step(76);
    a_ack = 1; a_ack_seq = 1; step(1); a_ack = 0;
    chk("t4_done", a_done, 1);
    chk("t4_retry", a_retry, 0);
    chk("t4_seq_wrap", a_seq, 0);
    step(20);
    chk("t4_lines_idle", a_serial, 0);
    chk("t4_ready", a_ready, 1);

    // SEQ_BITS=2 instance: four ACKed packets, valid held across send_done
    b_data = bdat[0]; b_valid = 1; step(1); b_valid = 0;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b_seq_%0d", p), b_seq, p);
      capture(1, B_F);
      if (p == 1) begin
        chk("b_p1_lane0", cap[0], 16'h1404);
        chk("b_p1_lane1", cap[1], 16'h1402);
      end
      if (p == 3) begin
        chk("b_p3_lane0", cap[0], 16'h1FFC);
        chk("b_p3_lane1", cap[1], 16'h1FFC);
      end
      step(3);
      if (p < 3) begin b_data = bdat[p+1]; b_valid = 1; end
      b_ack = 1; b_ack_seq = 2'(p); step(1); b_ack = 0;
      chk($sformatf("b_done_%0d", p), b_done, 1);
      if (p < 3) begin
        step(1); b_valid = 0;
        chk($sformatf("b_accept_first_idle_%0d", p), b_ready, 0);
      end
    end
    chk("b_seq_wrap", b_seq, 0);
    chk("b_no_fail", b_fail, 0);

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
